subword_mem_ctrl: RTL and testbench

//  Sequences CPU load/store requests of byte, halfword and word size onto a word-wide data memory.

---
 rtl/subword_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_subword_mem_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/subword_mem_ctrl.sv
// Byte/halfword/word load-store sequencer onto a word-wide, big-endian data RAM.
// Build option SUBWORD_BE_EN: sub-word stores use byte enables (mem_be) instead of read-modify-write.
module subword_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef SUBWORD_BE_EN
    output logic [3:0]        mem_be,
`endif
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int TERM_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TERM = TERM_I[CNT_W-1:0];
    localparam bit TMO_EN = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic set_err;

    logic we_q, byte_q, half_q, sext_q;
    logic [1:0] lane_q;
`ifndef SUBWORD_BE_EN
    logic [31:0] wdata_q;
    logic [31:0] merge_val;
`endif

    logic in_byte, in_half, misaligned, accept, ack, tmo_hit;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;

    assign in_byte    = (size == 2'b00);
    assign in_half    = (size == 2'b01);
    assign misaligned = (in_half && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign accept     = (state == IDLE) && req;
    assign ack        = mem_ack && mem_req;
    // The ack check has priority over this terminal count in the FSM below.
    assign tmo_hit    = TMO_EN && (cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        next_state = DONE;
                        set_err    = 1'b1;
                    end
`ifdef SUBWORD_BE_EN
                    else if (we) next_state = WR;
`else
                    else if (we && size[1]) next_state = WR;
`endif
                    else next_state = RD;
                end
            end
            RD: begin
                if (ack) next_state = we_q ? WR : DONE;
                else if (tmo_hit) begin
                    next_state = DONE;
                    set_err    = 1'b1;
                end
            end
            WR: begin
                if (ack) next_state = DONE;
                else if (tmo_hit) begin
                    next_state = DONE;
                    set_err    = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lane selection is big-endian: lane 0 lives in bits 31:24.
    always_comb begin
        case (lane_q)
            2'b00:   sel_byte = mem_rdata[31:24];
            2'b01:   sel_byte = mem_rdata[23:16];
            2'b10:   sel_byte = mem_rdata[15:8];
            default: sel_byte = mem_rdata[7:0];
        endcase
        sel_half = lane_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        if (byte_q)      load_val = {{24{sext_q & sel_byte[7]}}, sel_byte};
        else if (half_q) load_val = {{16{sext_q & sel_half[15]}}, sel_half};
        else             load_val = mem_rdata;
    end

`ifndef SUBWORD_BE_EN
    always_comb begin
        merge_val = mem_rdata;
        if (byte_q) begin
            case (lane_q)
                2'b00:   merge_val[31:24] = wdata_q[7:0];
                2'b01:   merge_val[23:16] = wdata_q[7:0];
                2'b10:   merge_val[15:8]  = wdata_q[7:0];
                default: merge_val[7:0]   = wdata_q[7:0];
            endcase
        end else if (half_q) begin
            if (lane_q[1]) merge_val[15:0]  = wdata_q[15:0];
            else           merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val = wdata_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            half_q    <= 1'b0;
            sext_q    <= 1'b0;
            lane_q    <= 2'b00;
`ifdef SUBWORD_BE_EN
            mem_be    <= 4'b0000;
`else
            wdata_q   <= '0;
`endif
        end else begin
            busy    <= (next_state != IDLE);
            done    <= (next_state == DONE);
            err     <= set_err;
            mem_req <= (next_state == RD) || (next_state == WR);
            mem_we  <= (next_state == WR);

            if ((next_state != state) && ((next_state == RD) || (next_state == WR)))
                cnt <= '0;
            else if (((state == RD) || (state == WR)) && !ack)
                cnt <= cnt + 1'b1;

            if (accept) begin
                mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                we_q     <= we;
                byte_q   <= in_byte;
                half_q   <= in_half;
                sext_q   <= sign_ext;
                lane_q   <= addr[1:0];
`ifdef SUBWORD_BE_EN
                if (in_byte)      mem_wdata <= {4{wdata[7:0]}};
                else if (in_half) mem_wdata <= {2{wdata[15:0]}};
                else              mem_wdata <= wdata;
                if (!we || size[1]) mem_be <= 4'b1111;
                else if (in_byte)   mem_be <= 4'b1000 >> addr[1:0];
                else                mem_be <= addr[1] ? 4'b0011 : 4'b1100;
`else
                wdata_q <= wdata;
                if (we && size[1]) mem_wdata <= wdata;
`endif
            end

            if ((state == RD) && ack) begin
                if (!we_q) rdata <= load_val;
`ifndef SUBWORD_BE_EN
                else       mem_wdata <= merge_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Scoreboard bench for subword_mem_ctrl with a behavioural word RAM (ACK_TIMEOUT=4).
module tb_subword_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef SUBWORD_BE_EN
    logic [3:0]  mem_be;
    localparam int RMW_LAT = 2;
`else
    localparam int RMW_LAT = 3;
`endif

    subword_mem_ctrl #(.ADDR_W(32), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef SUBWORD_BE_EN
        .mem_be(mem_be),
`endif
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          req_cyc;
        int          exp_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          req_total = 0;
    int          wait_cnt = 0;
    int          ack_delay = 0;
    int          r0;
    logic        ack_en = 1'b1;
    logic [31:0] mem [0:511];
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory: ack after ack_delay waiting cycles, writes honour byte enables when present.
    always @(negedge clk) begin
        if (mem_req) begin
            wait_cnt++;
            req_total++;
        end else begin
            wait_cnt = 0;
        end
        mem_ack   = mem_req && ack_en && (wait_cnt > ack_delay);
        mem_rdata = mem[mem_addr[10:2]];
    end

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack && mem_we) begin
`ifdef SUBWORD_BE_EN
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[10:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
            last_be = mem_be;
`else
            mem[mem_addr[10:2]] = mem_wdata;
`endif
            last_wdata = mem_wdata;
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                checkOutput($sformatf("t%0d_err", mon_e.id), {31'b0, err}, {31'b0, mon_e.exp_err});
                checkOutput($sformatf("t%0d_rdata", mon_e.id), rdata, mon_e.exp_rdata);
                checkOutput($sformatf("t%0d_latency", mon_e.id), cyc - mon_e.req_cyc, mon_e.exp_lat);
                checkOutput($sformatf("t%0d_memreq_low", mon_e.id), {31'b0, mem_req}, 32'd0);
            end
        end
    end

    task automatic applyStimulus(input int id, input logic w, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic e_err, input logic [31:0] e_rd, input int e_lat);
        int start;
        @(negedge clk);
        start = done_seen;
        sb.push_back('{id, e_err, e_rd, cyc, e_lat});
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 40 && done_seen == start; i++) @(negedge clk);
        if (done_seen == start) begin
            checks++;
            failures++;
            $display("[TB] FAIL t%0d_done_timeout actual=no_done required=done", id);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_err"}, {31'b0, err}, 32'd0);
        checkOutput({tag, "_memreq"}, {31'b0, mem_req}, 32'd0);
        checkOutput({tag, "_memwe"}, {31'b0, mem_we}, 32'd0);
        checkOutput({tag, "_rdata"}, rdata, 32'd0);
        checkOutput({tag, "_memaddr"}, mem_addr, 32'd0);
        checkOutput({tag, "_memwdata"}, mem_wdata, 32'd0);
`ifdef SUBWORD_BE_EN
        checkOutput({tag, "_membe"}, {28'b0, mem_be}, 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        checkResetOutputs("rst0");
        rst_n = 1'b1;

        mem[9'h040] = 32'h1122F344;
        applyStimulus(1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFFFFF3, 2);
        mem[9'h040] = 32'h8001ABCD;
        applyStimulus(2, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b0, 32'h00008001, 2);

        mem[9'h080] = 32'h11223344;
        applyStimulus(3, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000005A, 1'b0, 32'h00008001, RMW_LAT);
        checkOutput("t3_mem", mem[9'h080], 32'h115A3344);
`ifdef SUBWORD_BE_EN
        checkOutput("t3_be", {28'b0, last_be}, 32'h4);
        checkOutput("t3_wdata", last_wdata, 32'h5A5A5A5A);
`endif

        r0 = req_total;
        applyStimulus(4, 1'b1, 2'b10, 1'b0, 32'h302, 32'hDEADBEEF, 1'b1, 32'h00008001, 1);
        checkOutput("t4_no_memreq", req_total - r0, 32'd0);

        ack_en = 1'b0;
        r0 = req_total;
        applyStimulus(5, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h00008001, 5);
        checkOutput("t5_wait_cycles", req_total - r0, 32'd4);
        ack_en = 1'b1;

        ack_delay = 3;
        applyStimulus(6, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h8001ABCD, 5);
        ack_delay = 0;

        mem[9'h100] = 32'hA1B2C3D4;
        applyStimulus(7, 1'b0, 2'b00, 1'b0, 32'h403, 32'h0, 1'b0, 32'h000000D4, 2);
        applyStimulus(8, 1'b0, 2'b00, 1'b1, 32'h400, 32'h0, 1'b0, 32'hFFFFFFA1, 2);
        applyStimulus(9, 1'b0, 2'b01, 1'b1, 32'h402, 32'h0, 1'b0, 32'hFFFFC3D4, 2);
        applyStimulus(10, 1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 1'b1, 32'hFFFFC3D4, 1);

        applyStimulus(11, 1'b1, 2'b01, 1'b0, 32'h402, 32'h1234BEEF, 1'b0, 32'hFFFFC3D4, RMW_LAT);
        checkOutput("t11_mem", mem[9'h100], 32'hA1B2BEEF);
`ifdef SUBWORD_BE_EN
        checkOutput("t11_be", {28'b0, last_be}, 32'h3);
        checkOutput("t11_wdata", last_wdata, 32'hBEEFBEEF);
`endif

        applyStimulus(12, 1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFEF00D, 1'b0, 32'hFFFFC3D4, 2);
        checkOutput("t12_mem", mem[9'h140], 32'hCAFEF00D);
        applyStimulus(13, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 1'b0, 32'hCAFEF00D, 2);

        // Reset while a load is parked in RD waiting for an ack.
        ack_en = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h500;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checkOutput("rst1_in_rd", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst1");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (6) @(negedge clk);

        applyStimulus(14, 1'b0, 2'b00, 1'b0, 32'h501, 32'h0, 1'b0, 32'h000000FE, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
